// File: rtl/vis_arb_pkg.sv
// vis_arb_pkg: shared state/owner encodings and defaults for vis_bus_arbiter
package vis_arb_pkg;
    localparam logic [1:0] OWNER_NONE  = 2'b00;
    localparam logic [1:0] OWNER_A     = 2'b01;
    localparam logic [1:0] OWNER_B     = 2'b10;
    localparam logic [1:0] OWNER_DRAIN = 2'b11;
    localparam int MAXLEN_DEFAULT = 1024;
    typedef enum logic [1:0] {
        ST_IDLE  = OWNER_NONE,
        ST_OWN_A = OWNER_A,
        ST_OWN_B = OWNER_B,
        ST_DRAIN = OWNER_DRAIN
    } state_t;
endpackage

// File: rtl/vis_bus_arbiter.sv
// vis_bus_arbiter: two-way round-robin arbiter handing a correlator visibility stream to requester a or b
// Optional drop statistics counter built when VIS_ARB_STATS_EN is defined.
module vis_bus_arbiter
    import vis_arb_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int MAXLEN = MAXLEN_DEFAULT
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             vis_valid_i,
    output logic             vis_ready_o,
    input  logic             vis_last_i,
    input  logic [WIDTH-1:0] vis_revis_i,
    input  logic [WIDTH-1:0] vis_imvis_i,
    input  logic             a_req_i,
    output logic             a_gnt_o,
    output logic             a_valid_o,
    input  logic             a_ready_i,
    output logic             a_last_o,
    output logic [WIDTH-1:0] a_revis_o,
    output logic [WIDTH-1:0] a_imvis_o,
    input  logic             b_req_i,
    output logic             b_gnt_o,
    output logic             b_valid_o,
    input  logic             b_ready_i,
    output logic             b_last_o,
    output logic [WIDTH-1:0] b_revis_o,
    output logic [WIDTH-1:0] b_imvis_o,
    output logic [1:0]       owner_o,
    output logic             overrun_o,
    output logic [15:0]      drop_count_o
);
    localparam int CW = $clog2(MAXLEN + 1);

    state_t          r_state;
    state_t          w_next;
    logic            r_ptr;
    logic            r_in_frame;
    logic [CW-1:0]   r_cnt;
    logic            r_a_gnt;
    logic            r_b_gnt;
    logic            r_overrun;
    logic            w_xfer;
    logic            w_overrun;
    logic            w_end;
    logic            w_in_frame_nxt;
    logic            w_own_a;
    logic            w_own_b;

    assign w_xfer         = vis_valid_i & vis_ready_o;
    assign w_overrun      = w_xfer & ~vis_last_i & (r_cnt == CW'(MAXLEN - 1));
    assign w_end          = w_xfer & (vis_last_i | w_overrun);
    assign w_in_frame_nxt = w_xfer ? ~w_end : r_in_frame;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= ST_IDLE;
            r_ptr      <= 1'b0;
            r_in_frame <= 1'b0;
            r_cnt      <= '0;
            r_a_gnt    <= 1'b0;
            r_b_gnt    <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_ptr      <= (r_state == ST_OWN_A && w_next != ST_OWN_A) ? 1'b1 :
                          (r_state == ST_OWN_B && w_next != ST_OWN_B) ? 1'b0 : r_ptr;
            r_in_frame <= w_in_frame_nxt;
            r_cnt      <= w_end ? '0 : w_xfer ? r_cnt + CW'(1) : r_cnt;
            r_a_gnt    <= w_next == ST_OWN_A;
            r_b_gnt    <= w_next == ST_OWN_B;
            r_overrun  <= w_overrun;
        end
    end

    // A requester dropping mid-frame hands the rest of the frame to DRAIN so frames are never split
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  w_next = (a_req_i & (~b_req_i | ~r_ptr)) ? ST_OWN_A :
                               b_req_i ? ST_OWN_B : ST_IDLE;
            ST_OWN_A: w_next = w_end ? ST_IDLE : a_req_i ? ST_OWN_A :
                               w_in_frame_nxt ? ST_DRAIN : ST_IDLE;
            ST_OWN_B: w_next = w_end ? ST_IDLE : b_req_i ? ST_OWN_B :
                               w_in_frame_nxt ? ST_DRAIN : ST_IDLE;
            ST_DRAIN: w_next = w_end ? ST_IDLE : ST_DRAIN;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_own_a     = r_state == ST_OWN_A;
        w_own_b     = r_state == ST_OWN_B;
        vis_ready_o = w_own_a ? a_ready_i : w_own_b ? b_ready_i : (r_state == ST_DRAIN);
        a_valid_o   = w_own_a & vis_valid_i;
        a_last_o    = w_own_a & vis_last_i;
        a_revis_o   = w_own_a ? vis_revis_i : '0;
        a_imvis_o   = w_own_a ? vis_imvis_i : '0;
        b_valid_o   = w_own_b & vis_valid_i;
        b_last_o    = w_own_b & vis_last_i;
        b_revis_o   = w_own_b ? vis_revis_i : '0;
        b_imvis_o   = w_own_b ? vis_imvis_i : '0;
    end

    assign a_gnt_o   = r_a_gnt;
    assign b_gnt_o   = r_b_gnt;
    assign owner_o   = r_state;
    assign overrun_o = r_overrun;

`ifdef VIS_ARB_STATS_EN
    logic [15:0] r_drop_cnt;
    logic        w_drop_evt;
    assign w_drop_evt = (r_state == ST_DRAIN && w_next == ST_IDLE) | w_overrun;
    always_ff @(posedge clk_i) begin
        if (rst_i)
            r_drop_cnt <= '0;
        else if (w_drop_evt && r_drop_cnt != 16'hFFFF)
            r_drop_cnt <= r_drop_cnt + 16'd1;
    end
    assign drop_count_o = r_drop_cnt;
`else
    assign drop_count_o = '0;
`endif
endmodule

// File: tb/tb_vis_bus_arbiter.sv
// tb_vis_bus_arbiter: scoreboard bench for vis_bus_arbiter (MAXLEN=8); honours VIS_ARB_STATS_EN
module tb_vis_bus_arbiter;
    import vis_arb_pkg::*;
    localparam int W  = 16;
    localparam int ML = 8;
`ifdef VIS_ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic         vis_valid_i = 1'b0;
    logic         vis_ready_o;
    logic         vis_last_i = 1'b0;
    logic [W-1:0] vis_revis_i = '0;
    logic [W-1:0] vis_imvis_i = '0;
    logic         a_req_i = 1'b0, a_gnt_o, a_valid_o, a_ready_i = 1'b1, a_last_o;
    logic [W-1:0] a_revis_o, a_imvis_o;
    logic         b_req_i = 1'b0, b_gnt_o, b_valid_o, b_ready_i = 1'b1, b_last_o;
    logic [W-1:0] b_revis_o, b_imvis_o;
    logic [1:0]   owner_o;
    logic         overrun_o;
    logic [15:0]  drop_count_o;

    int            n_chk = 0;
    int            n_err = 0;
    int            exp_drop = 0;
    logic [34:0]   sb_q[$];

    vis_bus_arbiter #(.WIDTH(W), .MAXLEN(ML)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .vis_valid_i(vis_valid_i), .vis_ready_o(vis_ready_o), .vis_last_i(vis_last_i),
        .vis_revis_i(vis_revis_i), .vis_imvis_i(vis_imvis_i),
        .a_req_i(a_req_i), .a_gnt_o(a_gnt_o), .a_valid_o(a_valid_o), .a_ready_i(a_ready_i),
        .a_last_o(a_last_o), .a_revis_o(a_revis_o), .a_imvis_o(a_imvis_o),
        .b_req_i(b_req_i), .b_gnt_o(b_gnt_o), .b_valid_o(b_valid_o), .b_ready_i(b_ready_i),
        .b_last_o(b_last_o), .b_revis_o(b_revis_o), .b_imvis_o(b_imvis_o),
        .owner_o(owner_o), .overrun_o(overrun_o), .drop_count_o(drop_count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    // one beat; expected destination 1=a, 2=b, 3=drained
    task automatic send(input logic [1:0] dest, input logic last);
        int t = 0;
        vis_valid_i = 1'b1;
        vis_last_i  = last;
        vis_revis_i = W'($urandom);
        vis_imvis_i = W'($urandom);
        sb_q.push_back({dest, last, vis_revis_i, vis_imvis_i});
        #1;
        while (!vis_ready_o && t < 20) begin
            cyc();
            t++;
        end
        check("ready_timeout", 64'(t < 20), 1);
        check("nonowner_valid", dest == 2'd1 ? b_valid_o : dest == 2'd2 ? a_valid_o : (a_valid_o | b_valid_o), 0);
        cyc();
        vis_valid_i = 1'b0;
        vis_last_i  = 1'b0;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        cyc();
        rst_i = 1'b0;
        exp_drop = 0;
    endtask

    always @(negedge clk_i) begin
        logic [34:0] obs;
        logic        hit;
        hit = 1'b1;
        obs = '0;
        if (a_valid_o && a_ready_i)
            obs = {2'd1, a_last_o, a_revis_o, a_imvis_o};
        else if (b_valid_o && b_ready_i)
            obs = {2'd2, b_last_o, b_revis_o, b_imvis_o};
        else if (owner_o == OWNER_DRAIN && vis_valid_i && vis_ready_o)
            obs = {2'd3, vis_last_i, vis_revis_i, vis_imvis_i};
        else
            hit = 1'b0;
        if (hit) begin
            check("sb_depth", sb_q.size(), 1);
            if (sb_q.size() > 0) check("beat", obs, sb_q.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] e;
        int t;
        repeat (2) cyc();
        check("rst_owner", owner_o, OWNER_NONE);
        check("rst_a_gnt", a_gnt_o, 0);
        check("rst_b_gnt", b_gnt_o, 0);
        check("rst_overrun", overrun_o, 0);
        check("rst_drop", drop_count_o, 0);
        check("rst_ready", vis_ready_o, 0);
        rst_i = 1'b0;
        // single requester, 4-beat frame
        a_req_i = 1'b1;
        #1;
        check("a_gnt_pre", a_gnt_o, 0);
        cyc();
        check("a_owner", owner_o, OWNER_A);
        check("a_gnt", a_gnt_o, 1);
        check("a_b_gnt", b_gnt_o, 0);
        for (int i = 0; i < 4; i++) send(2'd1, i == 3);
        check("a_end_owner", owner_o, OWNER_NONE);
        check("a_end_gnt", a_gnt_o, 0);
        a_req_i = 1'b0;
        cyc();
        check("a_idle_hold", owner_o, OWNER_NONE);
        // round-robin with both requesting
        do_reset();
        a_req_i = 1'b1;
        b_req_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            e = (k == 1) ? 2'd2 : 2'd1;
            t = 0;
            while (owner_o == OWNER_NONE && t < 10) begin
                cyc();
                t++;
            end
            check("rr_owner", owner_o, e);
            check("rr_gnt", {a_gnt_o, b_gnt_o}, e == 2'd1 ? 2'b10 : 2'b01);
            send(e, 1'b0);
            send(e, 1'b1);
            check("rr_gap", owner_o, OWNER_NONE);
        end
        a_req_i = 1'b0;
        b_req_i = 1'b0;
        cyc();
        // b drops mid-frame -> drain
        b_req_i = 1'b1;
        cyc();
        check("b_owner", owner_o, OWNER_B);
        send(2'd2, 1'b0);
        send(2'd2, 1'b0);
        b_req_i = 1'b0;
        cyc();
        check("drain_owner", owner_o, OWNER_DRAIN);
        check("drain_ready", vis_ready_o, 1);
        check("drain_b_gnt", b_gnt_o, 0);
        for (int i = 3; i <= 6; i++) send(2'd3, i == 6);
        check("drain_end_owner", owner_o, OWNER_NONE);
        if (STATS) exp_drop++;
        check("drain_drop", drop_count_o, exp_drop);
        // overrun at MAXLEN beats
        a_req_i = 1'b1;
        cyc();
        check("ovr_owner", owner_o, OWNER_A);
        for (int i = 0; i < ML - 1; i++) send(2'd1, 1'b0);
        check("ovr_early", overrun_o, 0);
        send(2'd1, 1'b0);
        check("ovr_pulse", overrun_o, 1);
        check("ovr_owner_idle", owner_o, OWNER_NONE);
        a_req_i = 1'b0;
        if (STATS) exp_drop++;
        check("ovr_drop", drop_count_o, exp_drop);
        cyc();
        check("ovr_pulse_end", overrun_o, 0);
        check("ovr_no_drain", owner_o, OWNER_NONE);
        // reset mid-frame
        a_req_i = 1'b1;
        cyc();
        send(2'd1, 1'b0);
        send(2'd1, 1'b0);
        rst_i = 1'b1;
        send(2'd1, 1'b0);
        rst_i = 1'b0;
        exp_drop = 0;
        check("mrst_owner", owner_o, OWNER_NONE);
        check("mrst_a_gnt", a_gnt_o, 0);
        check("mrst_drop", drop_count_o, 0);
        check("mrst_overrun", overrun_o, 0);
        b_req_i = 1'b1;
        cyc();
        check("mrst_ptr_a", owner_o, OWNER_A);
        a_req_i = 1'b0;
        b_req_i = 1'b0;
        cyc();
        check("mrst_no_frame", owner_o, OWNER_NONE);
        // last beat together with request drop
        a_req_i = 1'b1;
        cyc();
        send(2'd1, 1'b0);
        a_req_i = 1'b0;
        send(2'd1, 1'b1);
        check("lastdrop_owner", owner_o, OWNER_NONE);
        check("lastdrop_drop", drop_count_o, exp_drop);
        cyc();
        check("lastdrop_hold", owner_o, OWNER_NONE);
        check("sb_left", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/vis_bus_arbiter.md
VIS_BUS_ARBITER -- requirements
Module: vis_bus_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32: bit width of each visibility component (real, imag).
REQ-002 SHALL have parameter MAXLEN, default 1024: maximum beats per frame before forced release.
REQ-003 SHALL have ports: clk_i  in  1  sole clock; one clock; reset is synchronous and active-high.
REQ-004 SHALL have rst_i  in  1  reset, synchronous, active-high.
REQ-005 SHALL have vis_valid_i  in  1; vis_ready_o  out  1; vis_last_i  in  1; vis_revis_i  in  WIDTH; vis_imvis_i  in  WIDTH: upstream correlator read port.
REQ-006 SHALL have, per requester X in {a, b}: X_req_i  in  1; X_gnt_o  out  1; X_valid_o  out  1; X_ready_i  in  1; X_last_o  out  1; X_revis_o  out  WIDTH; X_imvis_o  out  WIDTH.
REQ-007 SHALL have owner_o  out  2 (00 none, 01 a, 10 b, 11 drain); overrun_o  out  1 (one-cycle pulse); drop_count_o  out  16.

Function
REQ-008 SHALL implement FSM states IDLE, OWN_A, OWN_B, DRAIN; owner_o encodes state.
REQ-009 SHALL, in IDLE with only a_req_i high, enter OWN_A next edge; only b_req_i high, enter OWN_B; both high, grant side selected by round-robin pointer.
REQ-010 SHALL register X_gnt_o; it is high exactly while in OWN_X.
REQ-011 SHALL route upstream combinationally while owned: X_valid_o = vis_valid_i, X_last_o/data = upstream, vis_ready_o = X_ready_i; zero latency.
REQ-012 SHALL drive non-owner X_valid_o = 0, X_last_o = 0, data = 0; vis_ready_o = 0 in IDLE.
REQ-013 SHALL treat a beat as transferred when vis_valid_i && vis_ready_o.
REQ-014 SHALL keep in_frame flag: set on transferred beat without last, cleared on transferred beat with last.
REQ-015 SHALL, in OWN_X on transferred beat with last, go IDLE and set pointer to the other requester.
REQ-016 SHALL, in OWN_X with X_req_i low and in_frame clear, go IDLE and set pointer to the other requester.
REQ-017 SHALL, in OWN_X with X_req_i low and in_frame set, go DRAIN; frames are never split.
REQ-018 SHALL, in DRAIN, drive vis_ready_o = 1, all X_valid_o = 0, discard beats, go IDLE on transferred last beat.
REQ-019 SHALL give last-beat transfer priority over simultaneous X_req_i drop (IDLE, not DRAIN).
REQ-020 SHALL count transferred beats per frame; on reaching MAXLEN without last, pulse overrun_o, clear in_frame, go IDLE as if last.
REQ-021 SHALL insert at least one IDLE cycle between consecutive grants.

Reset
REQ-022 SHALL, with rst_i high at an edge: state IDLE, pointer = a, in_frame = 0, beat count = 0, all X_gnt_o = 0, overrun_o = 0, drop_count_o = 0.
REQ-023 SHALL abandon any frame in progress on reset; no DRAIN after reset.

Configuration
REQ-024 SHALL honour macro VIS_ARB_STATS_EN: when defined, drop_count_o increments (saturating at 16'hFFFF) on each DRAIN-to-IDLE transition and on each overrun; when undefined, drop_count_o is constant 0 and no counter is built.

Structure
REQ-025 SHALL take state enum, owner_o encodings and default MAXLEN from shared package vis_arb_pkg.
REQ-026 SHALL be a single module; no sub-module; two-way round-robin pick inline.

Verification
REQ-027 Only a_req_i=1, 4-beat frame, last on beat 4 -> a_gnt_o high cycle after request, 4 beats on a_*, IDLE after beat 4, b_valid_o stays 0.
REQ-028 a_req_i=b_req_i=1 continuously after reset, three 2-beat frames -> grants a, b, a; each separated by >=1 IDLE cycle.
REQ-029 OWN_B, b_req_i dropped after beat 2 of 6 -> owner_o=11, beats 3..6 consumed with vis_ready_o=1, b_valid_o=0, IDLE after beat 6, drop_count_o=1 (with VIS_ARB_STATS_EN), 0 (without).
REQ-030 MAXLEN=8, frame of 12 beats, no last by beat 8 -> overrun_o pulse on beat 8 edge, owner_o=00 next cycle.
REQ-031 rst_i asserted during beat 3 of OWN_A -> next cycle owner_o=00, a_gnt_o=0, drop_count_o=0, pointer=a.
REQ-032 Last beat and a_req_i drop in same cycle -> IDLE directly, no DRAIN, drop_count_o unchanged.
